mem_arbiter: RTL

- Shares one external memory port between I-cache and D-cache miss/write-back traffic, so the pipeline core plus both caches use a single memory bus.
- Sits between the two cache controllers' memory-side interfaces and the memory.
- Serialises transactions and arbitrates round-robin on a tie.
- Latches the winning request, holds it until memory completes, and inserts a turnaround gap so requesters can drop their request.
- Keeps saturating per-requester grant counters for performance measurement.

---
 rtl/mem_arbiter_pkg.sv | 24 ++
 rtl/mem_arbiter_sat_counter.sv | 30 +++
 rtl/mem_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the I/D-cache memory arbiter: state codes, requester IDs
// and the pipeline-wide memory bus width defaults.
package mem_arbiter_pkg;

    localparam int unsigned DefAddrW = 28;
    localparam int unsigned DefDataW = 128;
    localparam int unsigned DefCntW  = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StBusyI = 2'b01,
        StBusyD = 2'b10,
        StGap   = 2'b11
    } arb_state_e;

    localparam logic ReqI = 1'b0;
    localparam logic ReqD = 1'b1;

    // On a tie the requester that did not win last time gets the port.
    function automatic logic tie_picks_d(input logic last_grant);
        return last_grant == ReqI;
    endfunction

endpackage

// File: rtl/mem_arbiter_sat_counter.sv
// Saturating up-counter: increments on inc and holds at all-ones instead of wrapping.
module mem_arbiter_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between I-cache and D-cache traffic: latches the winning
// request, holds it until memory completes, then inserts a one-cycle turnaround.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned CNT_W  = DefCntW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_mem_read,
    input  logic [ADDR_W-1:0] i_mem_addr,
    output logic              i_mem_ready,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic              d_mem_ready,
    output logic [DATA_W-1:0] mem_rdata_out,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [CNT_W-1:0]  i_grant_cnt,
    output logic [CNT_W-1:0]  d_grant_cnt
);

    arb_state_e        state_q, state_d;
    logic              last_q, last_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic i_req, d_req;
    logic grant_i, grant_d;

    assign i_req   = i_mem_read;
    assign d_req   = d_mem_read | d_mem_write;
    assign grant_d = (state_q == StIdle) && d_req && (!i_req || tie_picks_d(last_q));
    assign grant_i = (state_q == StIdle) && i_req && !grant_d;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        unique case (state_q)
            StIdle: begin
                if (grant_d) begin
                    state_d     = StBusyD;
                    last_d      = ReqD;
                    mem_addr_d  = d_mem_addr;
                    mem_wdata_d = d_mem_wdata;
                    // Read+write together is illegal; the write wins.
                    mem_read_d  = d_mem_read & ~d_mem_write;
                    mem_write_d = d_mem_write;
                end else if (grant_i) begin
                    state_d     = StBusyI;
                    last_d      = ReqI;
                    mem_addr_d  = i_mem_addr;
                    mem_read_d  = 1'b1;
                    mem_write_d = 1'b0;
                end
            end
            StBusyI, StBusyD: begin
                if (mem_ready) begin
                    state_d     = StGap;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end
            end
            StGap: begin
                // Requests are deliberately not sampled here so a request held one
                // cycle past its ready is not granted a second time.
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            last_q      <= ReqI;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    mem_arbiter_sat_counter #(
        .CNT_W (CNT_W)
    ) u_i_cnt (
        .clk (clk),
        .rst (rst),
        .inc (grant_i),
        .cnt (i_grant_cnt)
    );

    mem_arbiter_sat_counter #(
        .CNT_W (CNT_W)
    ) u_d_cnt (
        .clk (clk),
        .rst (rst),
        .inc (grant_d),
        .cnt (d_grant_cnt)
    );

    assign i_mem_ready   = (state_q == StBusyI) && mem_ready;
    assign d_mem_ready   = (state_q == StBusyD) && mem_ready;
    assign mem_rdata_out = mem_rdata;
    assign mem_read      = mem_read_q;
    assign mem_write     = mem_write_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;

endmodule
